// File: rtl/pe_ns_pkg.sv
// pe_ns_pkg: shared FSM state type and buffer select constants for the PE loader
package pe_ns_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam logic BUF_DATA = 1'b0;
  localparam logic BUF_WEIGHT = 1'b1;
endpackage

// File: rtl/pe_ns_loader.sv
// pe_ns_loader: streams words into the data/weight buffers around PE writebacks; range error gated by PE_NS_RANGE_CHECK_EN
module pe_ns_loader
  import pe_ns_pkg::*;
#(
  parameter int dataLen = 32,
  parameter int addrLen = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               ld_sel,
  input  logic [addrLen-1:0] ld_base,
  input  logic [addrLen:0]   ld_count,
  input  logic               ld_valid,
  input  logic [dataLen-1:0] ld_data,
  output logic               ld_ready,
  input  logic               wb_valid,
  input  logic               wb_sel,
  input  logic [addrLen-1:0] wb_addr,
  input  logic [dataLen-1:0] wb_data,
  output logic               data_wrt,
  output logic [addrLen-1:0] data_wrt_addr,
  output logic [dataLen-1:0] data_in,
  output logic               weight_wrt,
  output logic [addrLen-1:0] weight_wrt_addr,
  output logic [dataLen-1:0] weight_in,
  output logic               busy,
  output logic               done,
  output logic               err
);
  state_t state;
  logic sel_q;
  logic [addrLen-1:0] addr_q;
  logic [addrLen:0] rem_q;
  logic xfer, wb_d, wb_w, ld_d, ld_w;
  assign ld_ready = (state == LOAD) && !(wb_valid && wb_sel == sel_q);
  assign xfer = ld_valid && ld_ready;
  assign wb_d = wb_valid && wb_sel == BUF_DATA;
  assign wb_w = wb_valid && wb_sel == BUF_WEIGHT;
  assign ld_d = xfer && sel_q == BUF_DATA;
  assign ld_w = xfer && sel_q == BUF_WEIGHT;
`ifndef PE_NS_RANGE_CHECK_EN
  assign err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel_q <= 1'b0;
      addr_q <= '0;
      rem_q <= '0;
      data_wrt <= 1'b0;
      data_wrt_addr <= '0;
      data_in <= '0;
      weight_wrt <= 1'b0;
      weight_wrt_addr <= '0;
      weight_in <= '0;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef PE_NS_RANGE_CHECK_EN
      err <= 1'b0;
`endif
    end else begin
      data_wrt <= wb_d || ld_d;
      data_wrt_addr <= wb_d ? wb_addr : addr_q;
      data_in <= wb_d ? wb_data : ld_data;
      weight_wrt <= wb_w || ld_w;
      weight_wrt_addr <= wb_w ? wb_addr : addr_q;
      weight_in <= wb_w ? wb_data : ld_data;
      case (state)
        IDLE: if (start) begin
          sel_q <= ld_sel;
          addr_q <= ld_base;
          rem_q <= ld_count;
          state <= (ld_count == '0) ? DONE : LOAD;
          busy <= 1'b1;
          done <= (ld_count == '0);
`ifdef PE_NS_RANGE_CHECK_EN
          err <= ({2'b00, ld_base} + {1'b0, ld_count}) > {2'b01, {addrLen{1'b0}}};
`endif
        end
        LOAD: if (xfer) begin
          addr_q <= addr_q + 1'b1;
          rem_q <= rem_q - 1'b1;
          if (rem_q == {{addrLen{1'b0}}, 1'b1}) begin
            state <= DONE;
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pe_ns_loader.sv
// tb_pe_ns_loader: directed vectors checked every cycle against a transaction-level loader model
module tb_pe_ns_loader;
  localparam int DL = 32;
  localparam int AL = 5;
  localparam int DEPTH = 1 << AL;
  logic clk = 1'b0;
  logic reset, start, ld_sel, ld_valid, ld_ready, wb_valid, wb_sel;
  logic [AL-1:0] ld_base, wb_addr, data_wrt_addr, weight_wrt_addr;
  logic [AL:0] ld_count;
  logic [DL-1:0] ld_data, wb_data, data_in, weight_in;
  logic data_wrt, weight_wrt, busy, done, err;
  int total = 0;
  int bad = 0;
  int data_log[$];
  int weight_log[$];
  int done_cnt = 0;
  int m_phase, m_addr, m_left;
  bit m_sel, m_err;
  bit e_dw, e_ww, e_busy, e_done;
  int e_da, e_wa;
  logic [DL-1:0] e_dd, e_wd;
  bit exp_range_err;

  pe_ns_loader #(.dataLen(DL), .addrLen(AL)) dut (
    .clk(clk), .reset(reset), .start(start), .ld_sel(ld_sel), .ld_base(ld_base),
    .ld_count(ld_count), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_addr(wb_addr), .wb_data(wb_data),
    .data_wrt(data_wrt), .data_wrt_addr(data_wrt_addr), .data_in(data_in),
    .weight_wrt(weight_wrt), .weight_wrt_addr(weight_wrt_addr), .weight_in(weight_in),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string nm, input int q[$], input int e[$]);
    chk({nm, "_len"}, 64'(q.size()), 64'(e.size()));
    for (int i = 0; i < e.size() && i < q.size(); i++) chk({nm, "_addr"}, 64'(q[i]), 64'(e[i]));
  endtask

  // Load = a run of `left` words landing at consecutive addresses modulo the depth
  always @(posedge clk) begin
    bit rdy, x, wd, ww;
    if (reset) begin
      m_phase = 0; m_addr = 0; m_left = 0; m_sel = 0; m_err = 0;
      e_dw = 0; e_ww = 0; e_busy = 0; e_done = 0;
    end else begin
      rdy = m_phase == 1 && !(wb_valid && wb_sel == m_sel);
      x = rdy && ld_valid;
      wd = wb_valid && !wb_sel;
      ww = wb_valid && wb_sel;
      e_dw = wd || (x && !m_sel);
      e_ww = ww || (x && m_sel);
      e_da = wd ? int'(wb_addr) : m_addr;
      e_dd = wd ? wb_data : ld_data;
      e_wa = ww ? int'(wb_addr) : m_addr;
      e_wd = ww ? wb_data : ld_data;
      if (m_phase == 0) begin
        if (start) begin
          m_sel = ld_sel;
          m_addr = int'(ld_base);
          m_left = int'(ld_count);
          m_phase = (m_left == 0) ? 2 : 1;
          if (exp_range_err) m_err = (int'(ld_base) + int'(ld_count)) > DEPTH;
        end
      end else if (m_phase == 1) begin
        if (x) begin
          m_addr = (m_addr + 1) % DEPTH;
          m_left = m_left - 1;
          if (m_left == 0) m_phase = 2;
        end
      end else m_phase = 0;
      e_busy = m_phase != 0;
      e_done = m_phase == 2;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("err", err, m_err);
    chk("ld_ready", ld_ready, m_phase == 1 && !(wb_valid && wb_sel == m_sel));
    chk("data_wrt", data_wrt, e_dw);
    chk("weight_wrt", weight_wrt, e_ww);
    if (e_dw && data_wrt) begin
      chk("data_wrt_addr", data_wrt_addr, e_da);
      chk("data_in", data_in, e_dd);
    end
    if (e_ww && weight_wrt) begin
      chk("weight_wrt_addr", weight_wrt_addr, e_wa);
      chk("weight_in", weight_in, e_wd);
    end
    if (data_wrt) data_log.push_back(int'(data_wrt_addr));
    if (weight_wrt) weight_log.push_back(int'(weight_wrt_addr));
    if (done) done_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    ld_data = ld_data + 1;
    wb_data = wb_data + 32'h100;
  endtask

  task automatic clear_logs();
    data_log.delete();
    weight_log.delete();
    done_cnt = 0;
  endtask

  task automatic go(input logic sel, input int base, input int cnt);
    start = 1; ld_sel = sel; ld_base = AL'(base); ld_count = (AL+1)'(cnt);
    cyc();
    start = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      cyc();
      n++;
    end
    chk("idle_timeout", n < 40, 1);
    cyc();
  endtask

  initial begin
`ifdef PE_NS_RANGE_CHECK_EN
    exp_range_err = 1;
`else
    exp_range_err = 0;
`endif
    reset = 1; start = 0; ld_sel = 0; ld_base = '0; ld_count = '0; ld_valid = 0;
    ld_data = 32'hA000_0000; wb_valid = 0; wb_sel = 0; wb_addr = '0; wb_data = 32'hB000_0000;
    cyc(); cyc();
    chk("rst_busy", busy, 0);
    chk("rst_wrt", {data_wrt, weight_wrt, done, err}, 0);
    chk("rst_addr", {data_wrt_addr, weight_wrt_addr}, 0);
    chk("rst_data", {data_in, weight_in}, 0);
    reset = 0;
    cyc();
    // basic load
    clear_logs();
    go(0, 3, 4);
    ld_valid = 1;
    wait_idle();
    ld_valid = 0;
    chk_log("basic", data_log, '{3, 4, 5, 6});
    chk("basic_done", 64'(done_cnt), 1);
    // wrap into weight buffer
    clear_logs();
    go(1, 30, 4);
    ld_valid = 1;
    wait_idle();
    ld_valid = 0;
    chk_log("wrap", weight_log, '{30, 31, 0, 1});
    chk("wrap_err", err, exp_range_err);
    // writeback conflict on the loading buffer
    clear_logs();
    go(0, 10, 3);
    ld_valid = 1; wb_valid = 1; wb_sel = 0; wb_addr = 5'd9;
    #1 chk("conf_ready0", ld_ready, 0);
    cyc();
    chk("conf_ready1", ld_ready, 0);
    cyc();
    wb_valid = 0;
    wait_idle();
    ld_valid = 0;
    chk_log("conflict", data_log, '{9, 9, 10, 11, 12});
    chk("conf_err_clr", err, 0);
    // writeback to data alongside weight load
    clear_logs();
    go(1, 5, 2);
    ld_valid = 1; wb_valid = 1; wb_sel = 0; wb_addr = 5'd2;
    cyc();
    wb_valid = 0;
    chk("par_both", {data_wrt, weight_wrt}, 2'b11);
    chk("par_daddr", data_wrt_addr, 2);
    chk("par_waddr", weight_wrt_addr, 5);
    wait_idle();
    ld_valid = 0;
    chk_log("par_w", weight_log, '{5, 6});
    // zero count
    clear_logs();
    go(0, 7, 0);
    chk("zero_done", done, 1);
    chk("zero_nowrt", {data_wrt, weight_wrt}, 0);
    cyc();
    chk("zero_idle", {busy, done}, 0);
    // start ignored while loading
    clear_logs();
    go(0, 0, 3);
    ld_valid = 1; start = 1; ld_base = 5'd20; ld_count = 6'd10; ld_sel = 1;
    cyc();
    start = 0;
    wait_idle();
    ld_valid = 0;
    chk_log("ign", data_log, '{0, 1, 2});
    chk("ign_wlog", 64'(weight_log.size()), 0);
    // reset in the middle of a load
    clear_logs();
    go(0, 0, 5);
    ld_valid = 1;
    cyc(); cyc();
    reset = 1;
    cyc();
    reset = 0; ld_valid = 0;
    chk("mid_busy", busy, 0);
    chk("mid_wrt", data_wrt, 0);
    cyc();
    chk("mid_nowrt", {data_wrt, done}, 0);
    chk("mid_nodone", 64'(done_cnt), 0);
    clear_logs();
    go(0, 7, 2);
    ld_valid = 1;
    wait_idle();
    ld_valid = 0;
    chk_log("after_rst", data_log, '{7, 8});
    chk("after_done", 64'(done_cnt), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
